// File: rtl/stream_max_finder_pkg.sv
// ============================================================================
// max_pkg : shared state encoding and default sizing for stream_max_finder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package max_pkg;

  localparam int DEF_S = 8;
  localparam int DEF_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stream_max_finder_ncs.sv
// ============================================================================
// ncs : cascadable unsigned magnitude comparator (A vs B, with cascade inputs)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ncs #(
  parameter int S = 8
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         eq_in,
  input  logic         gt_in,
  output logic         eq_out,
  output logic         gt_out
);

  // A lower-significance stage only decides the result when this stage ties.
  assign eq_out = (a == b) & eq_in;
  assign gt_out = (a > b) | ((a == b) & gt_in);

endmodule

`default_nettype wire

// File: rtl/stream_max_finder.sv
// ============================================================================
// stream_max_finder : finds the maximum sample and its index over an N-sample frame
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module stream_max_finder
  import max_pkg::*;
#(
  parameter  int S  = DEF_S,
  parameter  int N  = DEF_N,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [S-1:0]  din,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [S-1:0]  max_out,
  output logic [IW-1:0] max_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state_q, state_d;
  logic [S-1:0]  max_q, max_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          cmp_gt;
  logic          cmp_eq_unused;
  logic          accept;

  ncs #(.S(S)) u_ncs (
    .a      (din),
    .b      (max_q),
    .eq_in  (1'b1),
    .gt_in  (1'b0),
    .eq_out (cmp_eq_unused),
    .gt_out (cmp_gt)
  );

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FIRST;
      end
      FIRST: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          max_d   = din;
          idx_d   = '0;
          cnt_d   = IW'(1);
          state_d = (N == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          // Strict greater-than keeps the earliest index on ties.
          if (cmp_gt) begin
            max_d = din;
            idx_d = cnt_q;
          end
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign max_out = max_q;
  assign max_idx = idx_q;

endmodule

`default_nettype wire
